sv32_ptw: RTL and testbench

Sv32 hardware page-table walker that services TLB misses and drives the fill interface of the 32-entry TLB.
- Accepts a walk request for a virtual address.
- Fetches the level-1 PTE and, if needed, the level-0 PTE over a simple req/ack memory port.
- Checks structural PTE validity, then issues a one-cycle TLB fill or reports a page fault.
- Sits between the MMU miss logic and the memory arbiter.

---
 rtl/sv32_ptw.sv | 226 ++++++++++++++++++++++
 tb/tb_sv32_ptw.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sv32_ptw.sv
`default_nettype none
// ============================================================================
// Module   : sv32_ptw
// Summary  : Sv32 hardware page-table walker. Fetches the level-1 and, when
//            needed, the level-0 PTE over a req/ack memory port, checks the
//            PTE structure and A/D bits, then pulses a TLB fill or a fault.
// Revision : 1.0  initial release
// ============================================================================
module sv32_ptw #(
  parameter int PADDR_WIDTH = 32   // must not exceed the 34-bit Sv32 PTE address
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   walk_req_i,
  input  logic [31:0]            walk_vaddr_i,
  input  logic                   walk_store_i,
  input  logic [21:0]            satp_ppn_i,
  input  logic                   abort_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   fault_o,
  output logic [1:0]             fault_cause_o,
  output logic                   mem_req_o,
  output logic [PADDR_WIDTH-1:0] mem_addr_o,
  input  logic                   mem_ack_i,
  input  logic [31:0]            mem_rdata_i,
  output logic                   fill_req_o,
  output logic [19:0]            fill_vpn_o,
  output logic [21:0]            fill_ppn_o,
  output logic [6:0]             fill_perm_o,
  output logic                   fill_superpage_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_L1_REQ = 3'd1,
    S_L0_REQ = 3'd2,
    S_FILL   = 3'd3,
    S_FAULT  = 3'd4,
    S_DRAIN  = 3'd5
  } state_t;

  localparam logic [1:0] C_CAUSE_INVALID  = 2'd0;
  localparam logic [1:0] C_CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] C_CAUSE_AD       = 2'd2;
  localparam logic [1:0] C_CAUSE_NOLEAF   = 2'd3;

  state_t                   state_q, state_d;
  logic [19:0]              vpn_q, vpn_d;         // vaddr[31:12] of the walk in flight
  logic                     store_q, store_d;
  logic [PADDR_WIDTH-1:0]   addr_q, addr_d;       // PTE address, held for the whole request
  logic [1:0]               cause_q, cause_d;
  logic [19:0]              fvpn_q, fvpn_d;
  logic [21:0]              fppn_q, fppn_d;
  logic [6:0]               fperm_q, fperm_d;
  logic                     fsp_q, fsp_d;

  // Full 34-bit PTE addresses; only the low PADDR_WIDTH bits reach the port.
  logic [33:0] l1_addr_full;
  logic [33:0] l0_addr_full;
  assign l1_addr_full = {satp_ppn_i, walk_vaddr_i[31:22], 2'b00};
  assign l0_addr_full = {mem_rdata_i[31:10], vpn_q[9:0], 2'b00};

  // PTE field decode of the returned read data.
  logic pte_v, pte_r, pte_w, pte_x, pte_a, pte_d;
  logic pte_invalid, pte_leaf, pte_misaligned, pte_ad_fail;
  assign pte_v          = mem_rdata_i[0];
  assign pte_r          = mem_rdata_i[1];
  assign pte_w          = mem_rdata_i[2];
  assign pte_x          = mem_rdata_i[3];
  assign pte_a          = mem_rdata_i[6];
  assign pte_d          = mem_rdata_i[7];
  assign pte_invalid    = !pte_v || (!pte_r && pte_w);
  assign pte_leaf       = pte_r || pte_x;
  assign pte_misaligned = (mem_rdata_i[19:10] != 10'd0);
  // The walker never updates A/D, so a missing A (or D on a store) faults.
  assign pte_ad_fail    = !pte_a || (store_q && !pte_d);

  // Bits that are architecturally present but not needed by the walker.
  logic unused_bits;
  assign unused_bits = ^{walk_vaddr_i[21:0], mem_rdata_i[9:8], l1_addr_full, l0_addr_full};

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      vpn_q   <= '0;
      store_q <= 1'b0;
      addr_q  <= '0;
      cause_q <= '0;
      fvpn_q  <= '0;
      fppn_q  <= '0;
      fperm_q <= '0;
      fsp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vpn_q   <= vpn_d;
      store_q <= store_d;
      addr_q  <= addr_d;
      cause_q <= cause_d;
      fvpn_q  <= fvpn_d;
      fppn_q  <= fppn_d;
      fperm_q <= fperm_d;
      fsp_q   <= fsp_d;
    end
  end

  // Next-state decode and the strobe outputs.
  always_comb begin
    state_d    = state_q;
    vpn_d      = vpn_q;
    store_d    = store_q;
    addr_d     = addr_q;
    cause_d    = cause_q;
    fvpn_d     = fvpn_q;
    fppn_d     = fppn_q;
    fperm_d    = fperm_q;
    fsp_d      = fsp_q;
    mem_req_o  = 1'b0;
    fill_req_o = 1'b0;
    done_o     = 1'b0;
    fault_o    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // abort wins over a same-cycle request, which is simply dropped
        if (walk_req_i && !abort_i) begin
          vpn_d   = walk_vaddr_i[31:12];
          store_d = walk_store_i;
          addr_d  = l1_addr_full[PADDR_WIDTH-1:0];
          state_d = S_L1_REQ;
        end
      end

      S_L1_REQ: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          if (abort_i) begin
            state_d = S_IDLE;
          end else if (pte_invalid) begin
            cause_d = C_CAUSE_INVALID;
            state_d = S_FAULT;
          end else if (pte_leaf) begin
            if (pte_misaligned) begin
              cause_d = C_CAUSE_MISALIGN;
              state_d = S_FAULT;
            end else if (pte_ad_fail) begin
              cause_d = C_CAUSE_AD;
              state_d = S_FAULT;
            end else begin
              fvpn_d  = vpn_q;
              fppn_d  = mem_rdata_i[31:10];
              fperm_d = mem_rdata_i[7:1];
              fsp_d   = 1'b1;
              state_d = S_FILL;
            end
          end else begin
            addr_d  = l0_addr_full[PADDR_WIDTH-1:0];
            state_d = S_L0_REQ;
          end
        end else if (abort_i) begin
          // the read is already on the bus; let it finish before idling
          state_d = S_DRAIN;
        end
      end

      S_L0_REQ: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          if (abort_i) begin
            state_d = S_IDLE;
          end else if (pte_invalid) begin
            cause_d = C_CAUSE_INVALID;
            state_d = S_FAULT;
          end else if (!pte_leaf) begin
            cause_d = C_CAUSE_NOLEAF;
            state_d = S_FAULT;
          end else if (pte_ad_fail) begin
            cause_d = C_CAUSE_AD;
            state_d = S_FAULT;
          end else begin
            fvpn_d  = vpn_q;
            fppn_d  = mem_rdata_i[31:10];
            fperm_d = mem_rdata_i[7:1];
            fsp_d   = 1'b0;
            state_d = S_FILL;
          end
        end else if (abort_i) begin
          state_d = S_DRAIN;
        end
      end

      S_FILL: begin
        fill_req_o = !abort_i;
        done_o     = !abort_i;
        state_d    = S_IDLE;
      end

      S_FAULT: begin
        fault_o = !abort_i;
        state_d = S_IDLE;
      end

      S_DRAIN: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o           = (state_q != S_IDLE);
  assign mem_addr_o       = addr_q;
  assign fault_cause_o    = cause_q;
  assign fill_vpn_o       = fvpn_q;
  assign fill_ppn_o       = fppn_q;
  assign fill_perm_o      = fperm_q;
  assign fill_superpage_o = fsp_q;

endmodule
`default_nettype wire

// File: tb/tb_sv32_ptw.sv
`default_nettype none
// ============================================================================
// Module   : tb_sv32_ptw
// Summary  : Self-checking bench for sv32_ptw: table of complete walks with a
//            latency-programmable PTE memory, plus directed abort/reset cases.
// Revision : 1.0  initial release
// ============================================================================
module tb_sv32_ptw;

  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          walk_req_i;
  logic [31:0]   walk_vaddr_i;
  logic          walk_store_i;
  logic [21:0]   satp_ppn_i;
  logic          abort_i;
  logic          busy_o, done_o, fault_o;
  logic [1:0]    fault_cause_o;
  logic          mem_req_o;
  logic [PW-1:0] mem_addr_o;
  logic          mem_ack_i;
  logic [31:0]   mem_rdata_i;
  logic          fill_req_o;
  logic [19:0]   fill_vpn_o;
  logic [21:0]   fill_ppn_o;
  logic [6:0]    fill_perm_o;
  logic          fill_superpage_o;

  always #5 clk = ~clk;

  sv32_ptw #(.PADDR_WIDTH(PW)) dut (
    .clk(clk), .rst(rst),
    .walk_req_i(walk_req_i), .walk_vaddr_i(walk_vaddr_i),
    .walk_store_i(walk_store_i), .satp_ppn_i(satp_ppn_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .fault_o(fault_o), .fault_cause_o(fault_cause_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .fill_req_o(fill_req_o), .fill_vpn_o(fill_vpn_o),
    .fill_ppn_o(fill_ppn_o), .fill_perm_o(fill_perm_o), .fill_superpage_o(fill_superpage_o)
  );

  typedef struct {
    logic [31:0] vaddr;
    logic        store;
    logic [21:0] satp;
    int          lat;     // wait cycles before each ack
    logic [31:0] l1a, l1d, l0a, l0d;
    logic        ok;      // 1: fill expected, 0: fault expected
    logic [1:0]  cause;
    logic [19:0] vpn;
    logic [21:0] ppn;
    logic [6:0]  perm;
    logic        sp;
    int          reads;
    int          ncyc;    // cycles after the accept edge until the pulse
  } vec_t;

  vec_t vecs[10];

  int checks = 0;
  int errors = 0;

  // PTE memory model controls (written by the main process only)
  logic        resp_en = 1'b0;
  int          lat = 0;
  logic [31:0] cur_l1a = '0, cur_l1d = '0, cur_l0a = '0, cur_l0d = '0;
  logic        man_ack = 1'b0;
  logic [31:0] man_data = '0;

  // PTE memory model state (written by the responder only)
  int          rd_cnt = 0, hold_err = 0, bad_addr = 0, wait_cnt = 0;
  logic        in_req = 1'b0;
  logic [31:0] req_addr = '0;
  logic        auto_ack = 1'b0;
  logic [31:0] auto_data = '0;

  // Fill outputs the DUT should be holding
  logic [19:0] m_vpn = '0;
  logic [21:0] m_ppn = '0;
  logic [6:0]  m_perm = '0;
  logic        m_sp = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Memory responder: evaluates 1 time unit after each falling edge so that
  // values set by the main process at the edge are already visible.
  initial begin
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      #1;
      auto_ack = 1'b0;
      if (resp_en && mem_req_o) begin
        if (!in_req) begin
          in_req   = 1'b1;
          req_addr = mem_addr_o;
          wait_cnt = 0;
        end else if (mem_addr_o != req_addr) begin
          hold_err++;
        end
        if (wait_cnt >= lat) begin
          auto_ack = 1'b1;
          if (mem_addr_o == cur_l1a)      auto_data = cur_l1d;
          else if (mem_addr_o == cur_l0a) auto_data = cur_l0d;
          else begin auto_data = 32'h0; bad_addr++; end
          rd_cnt++;
          in_req = 1'b0;
        end else begin
          wait_cnt++;
        end
      end else begin
        in_req = 1'b0;
      end
      mem_ack_i   = resp_en ? auto_ack  : man_ack;
      mem_rdata_i = resp_en ? auto_data : man_data;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic start_walk(input logic [31:0] va, input logic st, input logic [21:0] sp);
    walk_vaddr_i = va;
    walk_store_i = st;
    satp_ppn_i   = sp;
    walk_req_i   = 1'b1;
    @(negedge clk);
    walk_req_i   = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   n;
    logic got;
    logic saw_fill;
    int   rd0, h0, b0;
    cur_l1a = v.l1a; cur_l1d = v.l1d; cur_l0a = v.l0a; cur_l0d = v.l0d;
    lat = v.lat; resp_en = 1'b1;
    rd0 = rd_cnt; h0 = hold_err; b0 = bad_addr;
    start_walk(v.vaddr, v.store, v.satp);
    n = 1;
    chk($sformatf("v%0d_req_t1", idx), mem_req_o, 1);
    chk($sformatf("v%0d_l1addr", idx), mem_addr_o, v.l1a);
    got = 1'b0; saw_fill = 1'b0;
    while (!got && n < 60) begin
      if (fill_req_o) saw_fill = 1'b1;
      if (done_o || fault_o) got = 1'b1;
      else begin @(negedge clk); n++; end
    end
    chk($sformatf("v%0d_finished", idx), got, 1);
    chk($sformatf("v%0d_latency", idx), n, v.ncyc);
    chk($sformatf("v%0d_done", idx), done_o, v.ok);
    chk($sformatf("v%0d_fault", idx), fault_o, !v.ok);
    chk($sformatf("v%0d_reads", idx), rd_cnt - rd0, v.reads);
    chk($sformatf("v%0d_addr_hold", idx), hold_err - h0, 0);
    chk($sformatf("v%0d_bad_addr", idx), bad_addr - b0, 0);
    if (v.ok) begin
      chk($sformatf("v%0d_fill_req", idx), fill_req_o, 1);
      chk($sformatf("v%0d_vpn", idx), fill_vpn_o, v.vpn);
      chk($sformatf("v%0d_ppn", idx), fill_ppn_o, v.ppn);
      chk($sformatf("v%0d_perm", idx), fill_perm_o, v.perm);
      chk($sformatf("v%0d_sp", idx), fill_superpage_o, v.sp);
      m_vpn = v.vpn; m_ppn = v.ppn; m_perm = v.perm; m_sp = v.sp;
    end else begin
      chk($sformatf("v%0d_cause", idx), fault_cause_o, v.cause);
      chk($sformatf("v%0d_no_fill", idx), saw_fill, 0);
    end
    @(negedge clk);
    chk($sformatf("v%0d_pulse_end", idx), done_o | fault_o | fill_req_o, 0);
    chk($sformatf("v%0d_idle", idx), busy_o, 0);
    chk($sformatf("v%0d_hold", idx), {fill_vpn_o, fill_ppn_o, fill_perm_o, fill_superpage_o},
        {m_vpn, m_ppn, m_perm, m_sp});
  endtask

  initial begin
    logic seen;
    rst = 1'b1;
    walk_req_i = 1'b0; walk_vaddr_i = '0; walk_store_i = 1'b0;
    satp_ppn_i = '0; abort_i = 1'b0;

    //            vaddr         st    satp       lat l1a           l1d           l0a           l0d           ok    cause vpn       ppn       perm   sp    rd nc
    vecs[0] = '{32'h4000_1234, 1'b0, 22'h00080, 2, 32'h0008_0400, 32'h0002_0401, 32'h0008_1004, 32'h048D_14CF, 1'b1, 2'd0, 20'h40001, 22'h12345, 7'h67, 1'b0, 2, 7};
    vecs[1] = '{32'h8040_0000, 1'b0, 22'h00080, 0, 32'h0008_0804, 32'h0010_004B, 32'hFFFF_FFFC, 32'h0,         1'b1, 2'd0, 20'h80400, 22'h00400, 7'h25, 1'b1, 1, 2};
    vecs[2] = '{32'h8040_0000, 1'b0, 22'h00080, 0, 32'h0008_0804, 32'h0010_044B, 32'hFFFF_FFFC, 32'h0,         1'b0, 2'd1, 20'h0,     22'h0,     7'h0,  1'b0, 1, 2};
    vecs[3] = '{32'h4000_1234, 1'b1, 22'h00080, 0, 32'h0008_0400, 32'h0002_0401, 32'h0008_1004, 32'h048D_144F, 1'b0, 2'd2, 20'h0,     22'h0,     7'h0,  1'b0, 2, 3};
    vecs[4] = '{32'h4000_1234, 1'b0, 22'h00080, 1, 32'h0008_0400, 32'h0002_0401, 32'h0008_1004, 32'h0002_0401, 1'b0, 2'd3, 20'h0,     22'h0,     7'h0,  1'b0, 2, 5};
    vecs[5] = '{32'h4000_1234, 1'b0, 22'h00080, 0, 32'h0008_0400, 32'h0000_0004, 32'hFFFF_FFFC, 32'h0,         1'b0, 2'd0, 20'h0,     22'h0,     7'h0,  1'b0, 1, 2};
    vecs[6] = '{32'h4000_1234, 1'b1, 22'h00080, 0, 32'h0008_0400, 32'h0002_0401, 32'h0008_1004, 32'h048D_14CF, 1'b1, 2'd0, 20'h40001, 22'h12345, 7'h67, 1'b0, 2, 3};
    vecs[7] = '{32'h4000_1234, 1'b0, 22'h00080, 0, 32'h0008_0400, 32'h0000_0005, 32'hFFFF_FFFC, 32'h0,         1'b0, 2'd0, 20'h0,     22'h0,     7'h0,  1'b0, 1, 2};
    vecs[8] = '{32'h8040_0000, 1'b0, 22'h00080, 3, 32'h0008_0804, 32'h0010_000B, 32'hFFFF_FFFC, 32'h0,         1'b0, 2'd2, 20'h0,     22'h0,     7'h0,  1'b0, 1, 5};
    vecs[9] = '{32'h0000_0000, 1'b0, 22'h3FFFFF,0, 32'hFFFF_F000, 32'h0010_004B, 32'hFFFF_FFFC, 32'h0,         1'b1, 2'd0, 20'h00000, 22'h00400, 7'h25, 1'b1, 1, 2};

    repeat (2) @(negedge clk);
    chk("reset_outputs", {busy_o, done_o, fault_o, fault_cause_o, mem_req_o, fill_req_o, fill_superpage_o}, 0);
    chk("reset_addr", mem_addr_o, 0);
    chk("reset_fill", {fill_vpn_o, fill_ppn_o, fill_perm_o}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // abort in L0_REQ, ack arrives 5 cycles after the abort pulse
    resp_en = 1'b0;
    start_walk(32'h4000_1234, 1'b0, 22'h00080);
    chk("ab_l1addr", mem_addr_o, 32'h0008_0400);
    man_ack = 1'b1; man_data = 32'h0002_0401;
    @(negedge clk);
    man_ack = 1'b0;
    chk("ab_l0req", mem_req_o, 1);
    chk("ab_l0addr", mem_addr_o, 32'h0008_1004);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    seen = 1'b0;
    walk_vaddr_i = 32'h8040_0000;
    walk_req_i = 1'b1;
    for (int k = 3; k <= 7; k++) begin
      chk($sformatf("ab_drain_req_c%0d", k), mem_req_o, 1);
      chk($sformatf("ab_drain_addr_c%0d", k), mem_addr_o, 32'h0008_1004);
      chk($sformatf("ab_drain_busy_c%0d", k), busy_o, 1);
      if (done_o || fault_o) seen = 1'b1;
      if (k == 5) walk_req_i = 1'b0;
      if (k == 7) begin man_ack = 1'b1; man_data = 32'h048D_14CF; end
      @(negedge clk);
    end
    man_ack = 1'b0;
    if (done_o || fault_o) seen = 1'b1;
    chk("ab_idle_busy", busy_o, 0);
    chk("ab_idle_req", mem_req_o, 0);
    @(negedge clk);
    if (done_o || fault_o) seen = 1'b1;
    chk("ab_req_not_queued", busy_o, 0);
    chk("ab_no_pulse", seen, 0);
    chk("ab_fill_hold", fill_ppn_o, m_ppn);

    // asynchronous reset in the middle of L1_REQ
    start_walk(32'h4000_1234, 1'b0, 22'h00080);
    chk("rst_pre_req", mem_req_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_req", mem_req_o, 0);
    chk("rst_async_busy", busy_o, 0);
    chk("rst_async_fill", {fill_vpn_o, fill_ppn_o, fill_perm_o, fill_superpage_o}, 0);
    m_vpn = '0; m_ppn = '0; m_perm = '0; m_sp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vec(vecs[0], 10);

    // simultaneous walk_req and abort in IDLE, then a stray ack in IDLE
    resp_en = 1'b0;
    walk_vaddr_i = 32'h4000_1234;
    walk_req_i = 1'b1; abort_i = 1'b1;
    @(negedge clk);
    walk_req_i = 1'b0; abort_i = 1'b0;
    chk("simul_busy", busy_o, 0);
    chk("simul_req", mem_req_o, 0);
    man_ack = 1'b1; man_data = 32'h048D_14CF;
    @(negedge clk);
    man_ack = 1'b0;
    chk("stray_ack", {busy_o, done_o, fault_o, fill_req_o}, 0);

    // abort during FILL suppresses the strobes
    start_walk(32'h8040_0000, 1'b0, 22'h00080);
    man_ack = 1'b1; man_data = 32'h0010_004B;
    @(negedge clk);
    man_ack = 1'b0;
    chk("abfill_busy", busy_o, 1);
    abort_i = 1'b1;
    #1;
    chk("abfill_strobes", {fill_req_o, done_o}, 0);
    @(negedge clk);
    abort_i = 1'b0;
    chk("abfill_idle", {busy_o, done_o, fill_req_o}, 0);

    // abort during FAULT suppresses fault_o
    start_walk(32'h4000_1234, 1'b0, 22'h00080);
    man_ack = 1'b1; man_data = 32'h0000_0004;
    @(negedge clk);
    man_ack = 1'b0;
    abort_i = 1'b1;
    #1;
    chk("abfault_strobe", fault_o, 0);
    @(negedge clk);
    abort_i = 1'b0;
    chk("abfault_idle", {busy_o, fault_o}, 0);

    // abort in the same cycle as the L1 ack returns straight to IDLE
    start_walk(32'h4000_1234, 1'b0, 22'h00080);
    man_ack = 1'b1; man_data = 32'h0002_0401; abort_i = 1'b1;
    @(negedge clk);
    man_ack = 1'b0; abort_i = 1'b0;
    chk("abask_idle", {busy_o, mem_req_o}, 0);
    @(negedge clk);
    chk("abask_no_pulse", {busy_o, done_o, fault_o}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
